pe_array_cfg_loader: RTL

//  Sequencer that configures the 4x4 PEs_array from a context memory, then launches it.
//  On start it reads num_entries config words from ctx memory starting at base_addr.
//  It replays each word onto init_PE_array/PE_config as a one-cycle strobe.
//  It waits RUN_GAP idle cycles after the last word, then pulses run for one cycle.
//  It replaces the hand-written per-PE/LSU init tasks used by benches and the host.

---
 rtl/pe_array_cfg_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pe_array_cfg_loader.sv
// Context-memory driven configuration sequencer for the 4x4 PE array: streams
// config words onto init_PE_array/PE_config, waits a fixed gap, then launches the array.
module pe_array_cfg_loader #(
    parameter int PE_INST_W = 24,
    parameter int ADDR_W    = 6,
    parameter int RUN_GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        num_entries,
    output logic                   ctx_rd_en,
    output logic [ADDR_W-1:0]      ctx_addr,
    input  logic [PE_INST_W+8:0]   ctx_rd_data,
    output logic [8:0]             init_PE_array,
    output logic [PE_INST_W-1:0]   PE_config,
    output logic                   run,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CNT_W = $clog2(RUN_GAP + 2);
    // After a load the GAP state also covers the cycle that shows the final strobe.
    localparam logic [CNT_W-1:0] GAP_FROM_LOAD = CNT_W'(RUN_GAP);
    localparam logic [CNT_W-1:0] GAP_FROM_IDLE = CNT_W'((RUN_GAP > 0) ? RUN_GAP - 1 : 0);

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    logic [2:0]           state;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W:0]      num_q;
    logic [ADDR_W:0]      idx;
    logic [CNT_W-1:0]     gap_cnt;

    logic [3:0]           row_sel;
    logic [4:0]           unit_sel;
    logic [PE_INST_W-1:0] inst;
    logic [ADDR_W:0]      idx_inc;
    logic                 entry_ok;

    assign row_sel  = ctx_rd_data[PE_INST_W+8 -: 4];
    assign unit_sel = ctx_rd_data[PE_INST_W+4 -: 5];
    assign inst     = ctx_rd_data[PE_INST_W-1:0];
    assign idx_inc  = idx + 1'b1;
    assign entry_ok = is_onehot4(row_sel) && is_onehot5(unit_sel);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            base_q        <= '0;
            num_q         <= '0;
            idx           <= '0;
            gap_cnt       <= '0;
            ctx_rd_en     <= 1'b0;
            ctx_addr      <= '0;
            init_PE_array <= '0;
            PE_config     <= '0;
            run           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            // Strobe-style outputs default low; each state raises only what it owns.
            ctx_rd_en     <= 1'b0;
            ctx_addr      <= '0;
            init_PE_array <= '0;
            PE_config     <= '0;
            run           <= 1'b0;
            done          <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        num_q   <= num_entries;
                        idx     <= '0;
                        cfg_err <= 1'b0;
                        busy    <= 1'b1;
                        if (num_entries == '0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_FROM_IDLE;
                        end else begin
                            state     <= S_FETCH;
                            ctx_rd_en <= 1'b1;
                            ctx_addr  <= base_addr;
                        end
                    end
                end

                S_FETCH: begin
                    state <= S_LOAD;
                end

                // read data is valid here; its strobe appears next cycle
                S_LOAD: begin
                    if (entry_ok) begin
                        init_PE_array <= {row_sel, unit_sel};
                        PE_config     <= inst;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                    idx <= idx_inc;
                    if (idx_inc < num_q) begin
                        state     <= S_FETCH;
                        ctx_rd_en <= 1'b1;
                        ctx_addr  <= base_q + idx_inc[ADDR_W-1:0];
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_FROM_LOAD;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_RUN;
                        run   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                S_RUN: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
